spi_key_loader: RTL and testbench

- Parametrised successor to the fixed 16x48-bit SPI key loader used by the encryption core.
- Deserialises a chip-select-framed SPI bit stream into NUM_KEYS round keys of KEY_W bits each.
- Adds bit-order selection, per-key valid flags, a commit strobe, multi-frame loading, and framing/overrun error reporting.
- Sits between the external SPI pins and the cipher round-key inputs.

---
 rtl/spi_key_loader.sv | 181 ++++++++++++++++++
 tb/tb_spi_key_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_key_loader.sv
// spi_key_loader
//   Deserialises a chip-select-framed SPI bit stream into NUM_KEYS round keys
//   of KEY_W bits each, for the encryption core's round-key inputs.
//   Keys may be delivered in one frame or spread across several frames. Each
//   completed key is committed straight into its slot of key_bus.
//
//   Optional build macro: SPI_KEY_PARITY_EN
//     Each key is followed by one even-parity bit. A key is committed only if
//     the key bits and the parity bit XOR to 0. A failed check sets the sticky
//     parity_err output instead of committing.
//
// Ports
//   spi_clk    : sole clock, rising edge
//   reset      : async, active-high reset
//   spi_cs_n   : frame select, active low
//   spi_data   : serial data, sampled on the rising edge
//   key_clr    : sync clear pulse; restarts loading at key 0 (key_bus kept)
//   key_bus    : flattened keys, key k at [k*KEY_W +: KEY_W]
//   key_valid  : per-key committed flags
//   key_wr     : one-cycle pulse in the cycle after each commit edge
//   key_idx    : slot currently being filled (saturates at NUM_KEYS-1)
//   load_done  : all keys committed
//   frame_err  : sticky, cs_n rose with a key partially received
//   parity_err : sticky, parity check failed (SPI_KEY_PARITY_EN only)
//   overrun    : sticky, bit received after load_done
module spi_key_loader #(
  parameter int KEY_W     = 48,
  parameter int NUM_KEYS  = 16,
  parameter int MSB_FIRST = 1,
  parameter int IDX_W     = $clog2(NUM_KEYS)
) (
  input  logic                      spi_clk,
  input  logic                      reset,
  input  logic                      spi_cs_n,
  input  logic                      spi_data,
  input  logic                      key_clr,
  output logic [NUM_KEYS*KEY_W-1:0] key_bus,
  output logic [NUM_KEYS-1:0]       key_valid,
  output logic                      key_wr,
  output logic [IDX_W-1:0]          key_idx,
  output logic                      load_done,
  output logic                      frame_err,
`ifdef SPI_KEY_PARITY_EN
  output logic                      parity_err,
`endif
  output logic                      overrun
);

`ifdef SPI_KEY_PARITY_EN
  localparam int SLOT_W = KEY_W + 1;
`else
  localparam int SLOT_W = KEY_W;
`endif
  localparam int CNT_W = $clog2(SLOT_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;

  state_t                         state_q, state_d;
  logic [NUM_KEYS-1:0][KEY_W-1:0] keys_q, keys_d;
  logic [NUM_KEYS-1:0]            valid_q, valid_d;
  logic [KEY_W-1:0]               sr_q, sr_d;
  logic [CNT_W-1:0]               bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic                           key_wr_q, key_wr_d;
  logic                           ferr_q, ferr_d;
  logic                           ovr_q, ovr_d;
  logic                           perr_q, perr_d;

  logic [KEY_W-1:0] shifted, word;
  logic             last_bit, key_bit, par_ok;

  always_comb begin
    if (MSB_FIRST != 0) shifted = {sr_q[KEY_W-2:0], spi_data};
    else                shifted = {spi_data, sr_q[KEY_W-1:1]};
    last_bit = (bit_cnt_q == CNT_W'(SLOT_W - 1));
`ifdef SPI_KEY_PARITY_EN
    // Last slot bit is the parity bit: it is checked, never shifted in.
    key_bit = !last_bit;
    word    = sr_q;
    par_ok  = ~(^sr_q ^ spi_data);
`else
    // The completing bit goes straight to the slot along with the rest.
    key_bit = 1'b1;
    word    = shifted;
    par_ok  = 1'b1;
`endif
  end

  always_comb begin
    state_d   = state_q;
    keys_d    = keys_q;
    valid_d   = valid_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    idx_d     = idx_q;
    key_wr_d  = 1'b0;
    ferr_d    = ferr_q;
    ovr_d     = ovr_q;
    perr_d    = perr_q;

    if (key_clr) begin
      // Clear takes priority over any coincident bit or commit.
      valid_d   = '0;
      idx_d     = '0;
      bit_cnt_d = '0;
      sr_d      = '0;
      ferr_d    = 1'b0;
      ovr_d     = 1'b0;
      perr_d    = 1'b0;
      state_d   = spi_cs_n ? IDLE : SHIFT;
    end else if (state_q == FULL) begin
      if (!spi_cs_n) ovr_d = 1'b1;
    end else if (spi_cs_n) begin
      // Frame ended: drop partial bits; a partial key is a framing error.
      if (bit_cnt_q != '0) ferr_d = 1'b1;
      bit_cnt_d = '0;
      sr_d      = '0;
      state_d   = IDLE;
    end else begin
      // Bit sampled with cs_n low is accepted, including on the IDLE exit edge.
      state_d = SHIFT;
      if (key_bit) sr_d = shifted;
      if (last_bit) begin
        bit_cnt_d = '0;
        sr_d      = '0;
        if (par_ok) begin
          keys_d[idx_q]  = word;
          valid_d[idx_q] = 1'b1;
          key_wr_d       = 1'b1;
          if (idx_q == IDX_W'(NUM_KEYS - 1)) state_d = FULL;
          else                               idx_d   = idx_q + IDX_W'(1);
        end else begin
          perr_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge spi_clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      keys_q    <= '0;
      valid_q   <= '0;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      idx_q     <= '0;
      key_wr_q  <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      keys_q    <= keys_d;
      valid_q   <= valid_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      idx_q     <= idx_d;
      key_wr_q  <= key_wr_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      perr_q    <= perr_d;
    end
  end

  assign key_bus   = keys_q;
  assign key_valid = valid_q;
  assign key_wr    = key_wr_q;
  assign key_idx   = idx_q;
  assign load_done = (state_q == FULL);
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
`ifdef SPI_KEY_PARITY_EN
  assign parity_err = perr_q;
`else
  logic unused_perr;
  assign unused_perr = perr_q;
`endif

endmodule

// File: tb/tb_spi_key_loader.sv
// Directed bench for spi_key_loader: instance a uses defaults, instance b
// uses MSB_FIRST = 0. Parity cases build only with SPI_KEY_PARITY_EN.
module tb_spi_key_loader;

`ifdef SPI_KEY_PARITY_EN
  localparam int SLOT = 49;
`else
  localparam int SLOT = 48;
`endif

  logic         spi_clk = 1'b0;
  logic         reset   = 1'b1;
  logic         key_clr = 1'b0;
  logic         a_cs_n = 1'b1, a_data = 1'b0;
  logic         b_cs_n = 1'b1, b_data = 1'b0;
  logic [767:0] a_bus, b_bus, saved;
  logic [15:0]  a_valid, b_valid;
  logic [3:0]   a_idx, b_idx;
  logic         a_wr, b_wr, a_done, b_done, a_ferr, b_ferr, a_ovr, b_ovr;
`ifdef SPI_KEY_PARITY_EN
  logic         a_perr, b_perr;
`endif

  int n_checks = 0;
  int n_errs   = 0;
  int wr_cnt   = 0;
  int wr_base;

  logic [47:0] kv [16] = '{
    48'hffffffffffff, 48'h000000000000, 48'hffffff000000, 48'h000000ffffff,
    48'haaaaaaaaaaaa, 48'h555555555555, 48'hcccccccccccc, 48'h333333333333,
    48'h249249249249, 48'h492492492492, 48'h6db6db6db6db, 48'h924924924924,
    48'hb6db6db6db6d, 48'hdb6db6db6db6, 48'h999999999999, 48'h666666666666};

  logic [63:0] s;

  spi_key_loader u_a (
    .spi_clk(spi_clk), .reset(reset), .spi_cs_n(a_cs_n), .spi_data(a_data),
    .key_clr(key_clr), .key_bus(a_bus), .key_valid(a_valid), .key_wr(a_wr),
    .key_idx(a_idx), .load_done(a_done), .frame_err(a_ferr),
`ifdef SPI_KEY_PARITY_EN
    .parity_err(a_perr),
`endif
    .overrun(a_ovr));

  spi_key_loader #(.MSB_FIRST(0)) u_b (
    .spi_clk(spi_clk), .reset(reset), .spi_cs_n(b_cs_n), .spi_data(b_data),
    .key_clr(1'b0), .key_bus(b_bus), .key_valid(b_valid), .key_wr(b_wr),
    .key_idx(b_idx), .load_done(b_done), .frame_err(b_ferr),
`ifdef SPI_KEY_PARITY_EN
    .parity_err(b_perr),
`endif
    .overrun(b_ovr));

  always #5 spi_clk = ~spi_clk;

  always @(negedge spi_clk) if (a_wr) wr_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge spi_clk);
    #1;
  endtask

  // Send the low n bits of v, highest first.
  task automatic send_raw(input bit sel, input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      if (sel) begin b_cs_n = 1'b0; b_data = v[i]; end
      else     begin a_cs_n = 1'b0; a_data = v[i]; end
      tick();
    end
  endtask

  function automatic logic [63:0] slot_of(input logic [47:0] k);
`ifdef SPI_KEY_PARITY_EN
    return {15'd0, k, ^k};
`else
    return {16'd0, k};
`endif
  endfunction

  task automatic send_key(input bit sel, input logic [47:0] k);
    send_raw(sel, slot_of(k), SLOT);
  endtask

  task automatic idle(input int n);
    a_cs_n = 1'b1;
    b_cs_n = 1'b1;
    repeat (n) tick();
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    @(negedge spi_clk) reset = 1'b0;
    tick();
    check("rst_bus",   64'(|a_bus), 0);
    check("rst_valid", 64'(a_valid), 0);
    check("rst_idx",   64'(a_idx), 0);
    check("rst_done",  64'(a_done), 0);
    check("rst_wr",    64'(a_wr), 0);
    check("rst_ferr",  64'(a_ferr), 0);
    check("rst_ovr",   64'(a_ovr), 0);

    // LSB-first variant: first received bit lands in bit 0
    send_key(1'b1, 48'h000000000001);
    check("lsbf_key0", 64'(b_bus[47:0]), 64'h800000000000);
    idle(1);

    // Full 16-key load in one frame
    for (int i = 0; i < 16; i++) begin
      send_key(1'b0, kv[i]);
      if (i == 0) begin
        check("k0_zero_lat", 64'(a_bus[47:0]), 64'(kv[0]));
        check("k0_wr",       64'(a_wr), 1);
        check("k0_valid",    64'(a_valid), 1);
      end
    end
    for (int i = 0; i < 16; i++) check($sformatf("slot%0d", i), 64'(a_bus[i*48 +: 48]), 64'(kv[i]));
    check("load_valid", 64'(a_valid), 64'hffff);
    check("load_done",  64'(a_done), 1);
    check("load_idx",   64'(a_idx), 15);
    saved = a_bus;

    // Overrun: extra bits after load_done
    send_raw(1'b0, 64'h16, 5);
    check("wr_pulses", 64'(wr_cnt), 16);
    check("ovr_set",   64'(a_ovr), 1);
    check("ovr_bus",   64'(a_bus == saved), 1);
    idle(1);
    key_clr = 1'b1;
    tick();
    key_clr = 1'b0;
    check("clr_valid", 64'(a_valid), 0);
    check("clr_idx",   64'(a_idx), 0);
    check("clr_done",  64'(a_done), 0);
    check("clr_ovr",   64'(a_ovr), 0);
    check("clr_bus",   64'(a_bus == saved), 1);

    // Multi-frame load, then cs_n rising mid-key 3
    for (int i = 0; i < 3; i++) begin
      send_key(1'b0, kv[i]);
      idle(2);
    end
    check("mf_ferr",  64'(a_ferr), 0);
    check("mf_idx",   64'(a_idx), 3);
    s = slot_of(48'hfedcba987654);
    send_raw(1'b0, s >> (SLOT - 20), 20);
    idle(1);
    check("fe_set",   64'(a_ferr), 1);
    check("fe_idx",   64'(a_idx), 3);
    check("fe_valid", 64'(a_valid), 64'h0007);
    check("fe_slot3", 64'(a_bus[3*48 +: 48]), 64'(kv[3]));
    send_key(1'b0, 48'h123456789abc);
    check("fe_new3",  64'(a_bus[3*48 +: 48]), 64'h123456789abc);
    check("fe_idx4",  64'(a_idx), 4);
    check("fe_slot4", 64'(a_bus[4*48 +: 48]), 64'(kv[4]));

    // Async reset during bit 30 of key 7
    for (int i = 4; i < 7; i++) send_key(1'b0, kv[i]);
    s = slot_of(48'h0f0f0f0f0f0f);
    send_raw(1'b0, s >> (SLOT - 30), 30);
    #2 reset = 1'b1;
    #1;
    check("ar_bus",   64'(|a_bus), 0);
    check("ar_valid", 64'(a_valid), 0);
    check("ar_idx",   64'(a_idx), 0);
    check("ar_ferr",  64'(a_ferr), 0);
    @(negedge spi_clk) reset = 1'b0;
    idle(1);
    send_key(1'b0, 48'h0badc0ffee01);
    check("ar_k0",   64'(a_bus[47:0]), 64'h0badc0ffee01);
    check("ar_idx1", 64'(a_idx), 1);
    idle(2);

    // key_clr coinciding with a commit edge
    wr_base = wr_cnt;
    s = slot_of(48'h5a5a5a5a5a5a);
    send_raw(1'b0, s >> 1, SLOT - 1);
    a_cs_n  = 1'b0;
    a_data  = s[0];
    key_clr = 1'b1;
    tick();
    key_clr = 1'b0;
    idle(2);
    check("cc_idx",   64'(a_idx), 0);
    check("cc_valid", 64'(a_valid), 0);
    check("cc_slot1", 64'(a_bus[95:48]), 0);
    check("cc_wr",    64'(wr_cnt - wr_base), 0);
    check("cc_ferr",  64'(a_ferr), 0);

`ifdef SPI_KEY_PARITY_EN
    // Wrong parity rejected, correct parity commits
    wr_base = wr_cnt;
    send_raw(1'b0, {15'd0, 48'haaaaaaaaaaaa, 1'b1}, 49);
    idle(2);
    check("par_err",   64'(a_perr), 1);
    check("par_idx0",  64'(a_idx), 0);
    check("par_nowr",  64'(wr_cnt - wr_base), 0);
    send_raw(1'b0, {15'd0, 48'haaaaaaaaaaaa, 1'b0}, 49);
    idle(2);
    check("par_idx1",  64'(a_idx), 1);
    check("par_slot0", 64'(a_bus[47:0]), 64'haaaaaaaaaaaa);
    check("par_wr1",   64'(wr_cnt - wr_base), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
